// File: rtl/floor_request_latch_if.sv
//------------------------------------------------------------------------------
// Module      : floor_request_latch_if
// Description : Car-call buttons, current stop and request/door status bundle.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface floor_request_latch_if #(
    parameter int N_STOPS = 6
);
    logic [N_STOPS-1:0] buttons;
    logic [N_STOPS-1:0] car_at;
    logic [N_STOPS-1:0] destination;
    logic               door_open;
    logic               served;
    logic [2:0]         served_idx;

    modport master (
        output buttons,
        output car_at,
        input  destination,
        input  door_open,
        input  served,
        input  served_idx
    );

    modport slave (
        input  buttons,
        input  car_at,
        output destination,
        output door_open,
        output served,
        output served_idx
    );
endinterface

`default_nettype wire

// File: rtl/floor_request_latch.sv
//------------------------------------------------------------------------------
// Module      : floor_request_latch
// Description : Latches car-call buttons into a request vector and clears each
//               request after the car has dwelt DWELL_CYCLES at that stop.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module floor_request_latch #(
    parameter int N_STOPS      = 6,
    parameter int DWELL_CYCLES = 50,
    parameter int CNT_W        = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    floor_request_latch_if.slave  bus
);
    localparam int               IDX_W   = 3;
    localparam int               HC_W    = $clog2(N_STOPS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_SERVE = 2'd2
    } state_t;

    logic [N_STOPS-1:0] sync1_q, sync2_q, sync2_dly_q;
    logic [N_STOPS-1:0] pending_q, pending_d;
    logic [N_STOPS-1:0] entry_q, entry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    state_t             state_q, state_d;

    logic [N_STOPS-1:0] rise;
    logic [N_STOPS-1:0] clear_mask;
    logic [HC_W-1:0]    hot_count;
    logic [IDX_W-1:0]   car_idx;
    logic               car_onehot;
    logic               door_open;
    logic               served;

    assign rise = sync2_q & ~sync2_dly_q;

    always_comb begin
        hot_count = '0;
        car_idx   = '0;
        for (int i = 0; i < N_STOPS; i++) begin
            if (bus.car_at[i]) begin
                hot_count = hot_count + HC_W'(1);
                car_idx   = IDX_W'(i);
            end
        end
        car_onehot = (hot_count == HC_W'(1));
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        entry_d    = entry_q;
        idx_d      = idx_q;
        door_open  = 1'b0;
        served     = 1'b0;
        clear_mask = '0;
        case (state_q)
            ST_IDLE: begin
                if (car_onehot && pending_q[car_idx]) begin
                    state_d = ST_DWELL;
                    cnt_d   = '0;
                    entry_d = bus.car_at;
                    idx_d   = car_idx;
                end
            end
            ST_DWELL: begin
                door_open = 1'b1;
                // Any departure from the entry stop (incl. moving/invalid) aborts; request is kept.
                if (bus.car_at != entry_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_SERVE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SERVE: begin
                door_open  = 1'b1;
                served     = 1'b1;
                clear_mask = N_STOPS'(1) << idx_q;
                state_d    = ST_IDLE;
                cnt_d      = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Clear beats a same-cycle set: a press at the stop being served is dropped.
    assign pending_d = (pending_q | rise) & ~clear_mask;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            sync2_dly_q <= '0;
            pending_q   <= '0;
            entry_q     <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            state_q     <= ST_IDLE;
        end else begin
            sync1_q     <= bus.buttons;
            sync2_q     <= sync1_q;
            sync2_dly_q <= sync2_q;
            pending_q   <= pending_d;
            entry_q     <= entry_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
        end
    end

    assign bus.destination = pending_q;
    assign bus.door_open   = door_open;
    assign bus.served      = served;
    assign bus.served_idx  = served ? idx_q : '0;

endmodule

`default_nettype wire
